// File: rtl/bsg_bus_arbiter.sv
// Two-master arbiter for the BSG register bus, round-robin on simultaneous requests.
// Latency: s_valid one cycle after the request is seen; master response one cycle after s_ready.
// Backpressure: s_valid is held until s_ready or TIMEOUT cycles elapse; losing master holds its request.
module bsg_bus_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic              s_write,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic              last_q;
  logic              ok_q;
  logic [DATA_W-1:0] cap_q;
  logic              gnt_any;
  logic              gnt_idx;

  // Pick the requester; on a tie the master that was not served last wins.
  always_comb begin
    gnt_any = m0_valid | m1_valid;
    gnt_idx = 1'b0;
    if (m0_valid && m1_valid) gnt_idx = ~last_q;
    else                      gnt_idx = m1_valid;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: one transaction walks IDLE -> ISSUE -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = ISSUE;
      ISSUE:   if (s_ready || cnt_q == CNT_LAST) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch the granted request, count wait cycles, capture the outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_write <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      owner   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      cap_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            owner   <= gnt_idx;
            s_write <= gnt_idx ? m1_write : m0_write;
            s_addr  <= gnt_idx ? m1_addr  : m0_addr;
            s_wdata <= gnt_idx ? m1_wdata : m0_wdata;
            cnt_q   <= '0;
          end
        end
        ISSUE: begin
          if (s_ready) begin
            ok_q  <= 1'b1;
            cap_q <= s_write ? '0 : s_rdata;
          end else if (cnt_q == CNT_LAST) begin
            ok_q  <= 1'b0;
            cap_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP:    last_q <= owner;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state: request strobe, busy, and the owner's response pulse.
  always_comb begin
    s_valid  = (state_q == ISSUE);
    busy     = (state_q != IDLE);
    m0_ready = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = '0;
    m1_ready = 1'b0;
    m1_err   = 1'b0;
    m1_rdata = '0;
    if (state_q == RESP) begin
      if (owner == 1'b0) begin
        m0_ready = ok_q;
        m0_err   = ~ok_q;
        m0_rdata = ok_q ? cap_q : '0;
      end else begin
        m1_ready = ok_q;
        m1_err   = ~ok_q;
        m1_rdata = ok_q ? cap_q : '0;
      end
    end
  end

endmodule

// File: tb/tb_bsg_bus_arbiter.sv
// Bench for bsg_bus_arbiter: directed scenarios with literal expectations,
// then randomized masters/slave checked every cycle against a transaction-level model.
// Inputs change on the falling edge; outputs are compared 1ns after the rising edge.
module tb_bsg_bus_arbiter;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       m0_valid, m0_write, m1_valid, m1_write;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_ready, m0_err, m1_ready, m1_err;
  logic [7:0] m0_rdata, m1_rdata;
  logic       s_valid, s_write, s_ready;
  logic [7:0] s_addr, s_wdata, s_rdata;
  logic       busy, owner;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bsg_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .busy(busy), .owner(owner)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // A transaction is "open" from grant until its response cycle has passed.
  // While open and unanswered it is on the bus; 'waited' counts bus cycles.
  bit       md_open, md_answered, md_ok, md_owner, md_last;
  int       md_waited;
  bit       md_sw;
  bit [7:0] md_sa, md_sd, md_rd;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        md_open = 0; md_answered = 0; md_ok = 0; md_owner = 0; md_last = 1;
        md_waited = 0; md_sw = 0; md_sa = 0; md_sd = 0; md_rd = 0;
      end else if (md_answered) begin
        md_last = md_owner; md_answered = 0; md_open = 0;
      end else if (md_open) begin
        md_waited++;
        if (s_ready) begin
          md_answered = 1; md_ok = 1; md_rd = md_sw ? 8'h00 : s_rdata;
        end else if (md_waited == TIMEOUT) begin
          md_answered = 1; md_ok = 0; md_rd = 8'h00;
        end
      end else if (m0_valid || m1_valid) begin
        md_owner  = (m0_valid && m1_valid) ? !md_last : m1_valid;
        md_open   = 1;
        md_waited = 0;
        md_sw = md_owner ? m1_write : m0_write;
        md_sa = md_owner ? m1_addr  : m0_addr;
        md_sd = md_owner ? m1_wdata : m0_wdata;
      end
      #1;
      check("s_valid",  s_valid,  md_open && !md_answered);
      check("busy",     busy,     md_open);
      check("owner",    owner,    md_owner);
      check("s_write",  s_write,  md_sw);
      check("s_addr",   s_addr,   md_sa);
      check("s_wdata",  s_wdata,  md_sd);
      check("m0_ready", m0_ready, md_answered && md_ok && !md_owner);
      check("m0_err",   m0_err,   md_answered && !md_ok && !md_owner);
      check("m0_rdata", m0_rdata, (md_answered && md_ok && !md_owner) ? md_rd : 8'h00);
      check("m1_ready", m1_ready, md_answered && md_ok && md_owner);
      check("m1_err",   m1_err,   md_answered && !md_ok && md_owner);
      check("m1_rdata", m1_rdata, (md_answered && md_ok && md_owner) ? md_rd : 8'h00);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  // Waits for the given master's response pulse, drops its valid, reports cycles taken.
  task automatic wait_pulse(input int which, output int n);
    bit done;
    done = 0;
    n = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      cyc();
      n++;
      if (which == 0 ? (m0_ready | m0_err) : (m1_ready | m1_err)) begin
        done = 1;
        if (which == 0) m0_valid = 0; else m1_valid = 0;
      end
    end
    if (!done) begin
      check("pulse_timeout", 32'd0, 32'd1);
      n = -1;
    end
  endtask

  task automatic req(input int which, input bit wr, input logic [7:0] a, input logic [7:0] d);
    if (which == 0) begin m0_valid = 1; m0_write = wr; m0_addr = a; m0_wdata = d; end
    else            begin m1_valid = 1; m1_write = wr; m1_addr = a; m1_wdata = d; end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int sv_cnt;
    int mode;
    bit done;
    rst = 1; s_ready = 0; s_rdata = 0;
    m0_valid = 0; m0_write = 0; m0_addr = 0; m0_wdata = 0;
    m1_valid = 0; m1_write = 0; m1_addr = 0; m1_wdata = 0;
    repeat (3) cyc();
    check("rst_s_valid", s_valid, 0);
    check("rst_busy",    busy,    0);
    check("rst_owner",   owner,   0);
    check("rst_s_addr",  s_addr,  0);
    check("rst_m0_rdy",  m0_ready, 0);
    rst = 0;

    // Simultaneous requests alternate m0, m1, m0, m1.
    s_ready = 1; s_rdata = 8'h3C;
    req(0, 0, 8'h20, 8'h00); req(1, 0, 8'h21, 8'h00);
    wait_pulse(0, n);
    check("tie1_lat", n, 2); check("tie1_owner", owner, 0); check("tie1_rdata", m0_rdata, 8'h3C);
    wait_pulse(1, n);
    check("tie2_lat", n, 3); check("tie2_owner", owner, 1); check("tie2_rdata", m1_rdata, 8'h3C);
    cyc();
    req(0, 0, 8'h22, 8'h00); req(1, 0, 8'h23, 8'h00);
    wait_pulse(0, n); check("tie3_owner", owner, 0); check("tie3_lat", n, 2);
    wait_pulse(1, n); check("tie4_owner", owner, 1); check("tie4_lat", n, 3);
    cyc();

    // m0 write 0x10/0x05 accepted in the first bus cycle.
    req(0, 1, 8'h10, 8'h05);
    cyc();
    check("wr_s_valid", s_valid, 1); check("wr_s_addr", s_addr, 8'h10);
    check("wr_s_wdata", s_wdata, 8'h05); check("wr_s_write", s_write, 1);
    cyc();
    check("wr_m0_ready", m0_ready, 1); check("wr_m0_err", m0_err, 0);
    check("wr_s_valid_off", s_valid, 0); check("wr_m0_rdata", m0_rdata, 0);
    m0_valid = 0; s_ready = 0;
    cyc();
    check("wr_busy_clear", busy, 0);

    // m1 read 0x11 with three wait cycles, read data 0xA5.
    s_rdata = 8'hA5;
    req(1, 0, 8'h11, 8'h00);
    cyc(); check("rd_s_addr", s_addr, 8'h11);
    cyc(); cyc(); cyc();
    s_ready = 1;
    cyc();
    check("rd_m1_ready", m1_ready, 1); check("rd_m1_rdata", m1_rdata, 8'hA5);
    check("rd_m0_ready", m0_ready, 0); check("rd_m0_rdata", m0_rdata, 0); check("rd_m0_err", m0_err, 0);
    m1_valid = 0; s_ready = 0;
    cyc();

    // Slave never answers: exactly TIMEOUT bus cycles, then an error pulse.
    req(0, 0, 8'h12, 8'h00);
    sv_cnt = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      cyc();
      if (s_valid) sv_cnt++;
      if (m0_err || m0_ready) done = 1;
    end
    check("to_svalid_cycles", sv_cnt, TIMEOUT);
    check("to_m0_err", m0_err, 1); check("to_m0_ready", m0_ready, 0);
    check("to_m0_rdata", m0_rdata, 0);
    m0_valid = 0;
    cyc();
    check("to_busy_clear", busy, 0); check("to_err_pulse", m0_err, 0);

    // s_ready on the last allowed bus cycle still succeeds.
    s_rdata = 8'h5A;
    req(0, 0, 8'h12, 8'h00);
    repeat (TIMEOUT) cyc();
    check("edge_s_valid", s_valid, 1);
    s_ready = 1;
    cyc();
    check("edge_m0_ready", m0_ready, 1); check("edge_m0_err", m0_err, 0);
    check("edge_m0_rdata", m0_rdata, 8'h5A);
    m0_valid = 0; s_ready = 0;
    cyc();

    // Reset during the bus phase aborts silently; next tie goes to m0.
    req(1, 0, 8'h10, 8'h00);
    wait_pulse(1, n);
    req(0, 1, 8'h10, 8'h77);
    cyc(); cyc();
    rst = 1;
    cyc();
    check("rst_mid_s_valid", s_valid, 0); check("rst_mid_busy", busy, 0);
    check("rst_mid_m0_ready", m0_ready, 0); check("rst_mid_m0_err", m0_err, 0);
    rst = 0; s_ready = 1;
    req(1, 0, 8'h11, 8'h00);
    wait_pulse(0, n); check("rst_tie_owner", owner, 0); check("rst_tie_lat", n, 2);
    wait_pulse(1, n); check("rst_tie_m1_owner", owner, 1);
    s_ready = 0;
    cyc();

    // Randomized traffic checked by the model every cycle.
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) mode = $urandom_range(0, 2);
      if (m0_valid && (m0_ready || m0_err)) m0_valid = 0;
      else if (!m0_valid && $urandom_range(0, 3) == 0)
        req(0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      if (m1_valid && (m1_ready || m1_err)) m1_valid = 0;
      else if (!m1_valid && $urandom_range(0, 3) == 0)
        req(1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      case (mode)
        0:       s_ready = ($urandom_range(0, 1) == 1);
        1:       s_ready = ($urandom_range(0, 7) == 0);
        default: s_ready = ($urandom_range(0, 39) == 0);
      endcase
      s_rdata = 8'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      cyc();
    end
    rst = 0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
